s2b_window_cnt: RTL and testbench
=================================

S2B_WINDOW_CNT -- requirements
Module: s2b_window_cnt

Interface
REQ-001 Parameter CNT_W, default 8, log2 of window length; the window is 2^CNT_W bitstream cycles.
REQ-002 Parameter WARMUP, default 2, number of stream cycles discarded after operand load (upstream pipeline fill); legal range 0..15.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one conversion; sampled only in IDLE.
REQ-006 iBit  input  1  unipolar stochastic bitstream from the upstream MAC stage.
REQ-007 oLoad  output  1  one-cycle strobe to the upstream loadA/loadB inputs.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 oValid  output  1  result valid; high only in DONE.
REQ-010 iReady  input  1  consumer accepts the result when oValid && iReady.
REQ-011 oCount  output  CNT_W+1  number of ones counted in the window, range 0..2^CNT_W.

Function
REQ-012 FSM states: IDLE, LOAD, WARM, RUN, DONE; state is registered, and outputs decode from registered state and registers only.
REQ-013 IDLE -> LOAD on an edge with start=1; otherwise IDLE holds.
REQ-014 LOAD lasts exactly one cycle with oLoad=1; oLoad is 0 in all other states.
REQ-015 LOAD -> WARM if WARMUP>0, else LOAD -> RUN.
REQ-016 WARM lasts exactly WARMUP cycles; iBit is ignored; then WARM -> RUN.
REQ-017 Entry to RUN clears the ones counter and the CNT_W-bit window counter.
REQ-018 In RUN, each edge adds iBit to the ones counter and increments the window counter.
REQ-019 The ones counter is CNT_W+1 bits and cannot overflow, since at most 2^CNT_W ones are added.
REQ-020 RUN samples exactly 2^CNT_W edges; on the edge where the window counter equals 2^CNT_W-1:
- oCount loads the ones count plus the iBit sampled on that edge;
- state -> DONE.
REQ-021 Latency: start sampled at edge k gives oValid=1 after edge k+2+WARMUP+2^CNT_W-1 and oLoad=1 in the cycle after edge k.
REQ-022 In DONE, oValid=1 and oCount holds stable until the edge where iReady=1; that edge sets state -> IDLE and oValid -> 0.
REQ-023 oCount retains the last result in IDLE and changes only at the RUN -> DONE transition.
REQ-024 start is ignored in LOAD, WARM, RUN and DONE, including start=1 on the DONE+iReady edge; a new conversion needs start in IDLE.
REQ-025 iReady outside DONE has no effect.
REQ-026 Window counter wrap from 2^CNT_W-1 to 0 occurs only at the RUN exit and never causes an extra sample.

Reset
REQ-027 rst_n low forces state IDLE, with oLoad=0, busy=0, oValid=0, oCount=0, and both counters at 0, immediately and regardless of clk.
REQ-028 Reset asserted mid-operation in any state aborts the conversion with no partial result presented.
REQ-029 The first edge after rst_n deasserts behaves as IDLE.

Verification (CNT_W=8, WARMUP=2)
REQ-030 Stimulus: start pulse, iBit held 1, iReady=1.
- oLoad high for 1 cycle after the start edge.
- oValid rises 259 cycles after the start edge with oCount=256.
REQ-031 Stimulus: iBit held 0 during RUN, held 1 during WARM -> oCount=0, confirming warm-up bits are discarded.
REQ-032 Stimulus: iBit alternating 1,0 starting at the first RUN edge -> oCount=128.
REQ-033 Stimulus: result ready, iReady held low 10 cycles, then high.
- oValid and oCount remain stable for all 10 cycles.
- Both clear/return to IDLE on the iReady edge; busy falls on that edge.
REQ-034 Stimulus: start pulses during RUN and on the DONE+iReady edge -> no extra oLoad, no restart, and oCount equals the first window's count.
REQ-035 Stimulus: rst_n asserted after 100 RUN cycles, then a new start with iBit=1 -> outputs zero during reset, then a full new window with oCount=256.

Source files
------------

// File: rtl/s2b_window_cnt.sv
// s2b_window_cnt: counts ones of a stochastic bitstream over a 2^CNT_W-cycle window after an operand load and warm-up
module s2b_window_cnt #(
    parameter int CNT_W  = 8,
    parameter int WARMUP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             iBit,
    input  logic             iReady,
    output logic             oLoad,
    output logic             busy,
    output logic             oValid,
    output logic [CNT_W:0]   oCount
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WARM, S_RUN, S_DONE} state_t;

    localparam logic [3:0] WARM_LAST = (WARMUP > 0) ? 4'(WARMUP - 1) : 4'd0;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_warm;
    logic [CNT_W-1:0] r_win;
    logic [CNT_W:0]   r_ones;
    logic [CNT_W:0]   r_count;
    logic [CNT_W:0]   w_bit_ext;
    logic             w_warm_done;
    logic             w_win_last;
    logic             w_run_entry;

    assign w_bit_ext   = {{CNT_W{1'b0}}, iBit};
    assign w_warm_done = (r_warm == WARM_LAST);
    assign w_win_last  = &r_win;
    assign w_run_entry = (w_next == S_RUN) && (r_state != S_RUN);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = (WARMUP > 0) ? S_WARM : S_RUN;
            S_WARM:  w_next = w_warm_done ? S_RUN : S_WARM;
            S_RUN:   w_next = w_win_last ? S_DONE : S_RUN;
            S_DONE:  w_next = iReady ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // warm-up, window and ones counters; result captured on the last window edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm  <= '0;
            r_win   <= '0;
            r_ones  <= '0;
            r_count <= '0;
        end else begin
            r_warm <= (r_state == S_WARM) ? r_warm + 4'd1 : 4'd0;
            if (w_run_entry) begin
                r_win  <= '0;
                r_ones <= '0;
            end else if (r_state == S_RUN) begin
                r_win  <= r_win + 1'b1;
                r_ones <= r_ones + w_bit_ext;
            end
            if (r_state == S_RUN && w_win_last)
                r_count <= r_ones + w_bit_ext;
        end
    end

    assign oLoad  = (r_state == S_LOAD);
    assign busy   = (r_state != S_IDLE);
    assign oValid = (r_state == S_DONE);
    assign oCount = r_count;
endmodule

// File: tb/tb_s2b_window_cnt.sv
// tb_s2b_window_cnt: table-driven, hand-written and randomized checks of the window counter
module tb_s2b_window_cnt;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       iBit = 1'b0;
    logic       iReady = 1'b0;
    logic       oLoad;
    logic       busy;
    logic       oValid;
    logic [8:0] oCount;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        string name;
        int    pat;
        logic  warm_bit;
        int    rdy;
        logic  noise;
        int    exp;
    } vec_t;

    vec_t tbl[6];

    s2b_window_cnt #(.CNT_W(8), .WARMUP(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iBit(iBit),
        .oLoad(oLoad), .busy(busy), .oValid(oValid), .iReady(iReady), .oCount(oCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] gen(input int pat);
        logic [255:0] b;
        for (int i = 0; i < 256; i++)
            b[i] = (pat == 0) ? 1'b1 :
                   (pat == 1) ? 1'b0 :
                   (pat == 2) ? (i % 2 == 0) :
                   (pat == 3) ? (i % 4 == 3) :
                   (pat == 4) ? (i == 255) : (i == 0);
        return b;
    endfunction

    // one full conversion starting from IDLE; bits[i] is presented for the i-th RUN edge
    task automatic conv(input logic [255:0] bits, input logic wb, input int rdy,
                        input logic noise, input int exp, input string name);
        int   loads;
        int   cap;
        logic ok;
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, "_load_hi"}, oLoad, 1);
        check({name, "_busy_hi"}, busy, 1);
        loads = 0;
        iBit = wb;
        start = noise;
        step();
        check({name, "_load_1cyc"}, oLoad, 0);
        for (int w = 0; w < 2; w++) begin
            iBit = wb;
            start = noise ? 1'($urandom % 2) : 1'b0;
            step();
            loads += int'(oLoad);
        end
        for (int i = 0; i < 256; i++) begin
            iBit = bits[i];
            start = noise ? 1'($urandom % 2) : 1'b0;
            step();
            loads += int'(oLoad);
            if (i == 254) check({name, "_valid_early"}, oValid, 0);
        end
        check({name, "_valid_lat"}, oValid, 1);
        check({name, "_count"}, oCount, exp);
        check({name, "_no_extra_load"}, loads, 0);
        cap = int'(oCount);
        ok = 1'b1;
        start = 1'b0;
        iReady = 1'b0;
        for (int r = 0; r < rdy; r++) begin
            iBit = 1'($urandom % 2);
            step();
            if (oValid !== 1'b1 || int'(oCount) != cap) ok = 1'b0;
        end
        check({name, "_hold_stable"}, ok, 1);
        iReady = 1'b1;
        start = noise;
        step();
        check({name, "_valid_clr"}, oValid, 0);
        check({name, "_busy_clr"}, busy, 0);
        iReady = 1'b0;
        start = 1'b0;
        step();
        check({name, "_no_restart"}, {oLoad, busy}, 0);
        check({name, "_retain"}, oCount, exp);
    endtask

    initial begin
        logic [255:0] bits;
        int           exp;
        int           dens;
        tbl[0] = '{"all_ones",  0, 1'b0, 0,  1'b0, 256};
        tbl[1] = '{"zeros_w1",  1, 1'b1, 1,  1'b0, 0};
        tbl[2] = '{"alt",       2, 1'b0, 2,  1'b0, 128};
        tbl[3] = '{"quarter",   3, 1'b1, 10, 1'b0, 64};
        tbl[4] = '{"last_only", 4, 1'b1, 0,  1'b0, 1};
        tbl[5] = '{"noise",     0, 1'b1, 3,  1'b1, 256};

        #1;
        check("rst_async", {oLoad, busy, oValid, oCount}, 0);
        step();
        step();
        rst_n = 1'b1;
        iReady = 1'b1;
        step();
        check("idle_ready_ignored", {oLoad, busy, oValid}, 0);
        iReady = 1'b0;

        for (int v = 0; v < 6; v++)
            conv(gen(tbl[v].pat), tbl[v].warm_bit, tbl[v].rdy, tbl[v].noise, tbl[v].exp, tbl[v].name);

        start = 1'b1;
        step();
        start = 1'b0;
        iBit = 1'b1;
        for (int i = 0; i < 103; i++) step();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {oLoad, busy, oValid, oCount}, 0);
        step();
        step();
        check("mid_rst_hold", {oLoad, busy, oValid, oCount}, 0);
        rst_n = 1'b1;
        conv(gen(0), 1'b1, 1, 1'b0, 256, "post_rst");

        for (int t = 0; t < 6; t++) begin
            dens = $urandom_range(0, 100);
            exp = 0;
            for (int i = 0; i < 256; i++) begin
                bits[i] = ($urandom_range(0, 99) < dens);
                exp += int'(bits[i]);
            end
            conv(bits, 1'($urandom % 2), $urandom_range(0, 4), 1'($urandom % 2), exp,
                 $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
